half_mult_result_buffer: RTL
============================

# half_mult_result_buffer

Registered result stage directly downstream of the combinational half-precision multiplier. It captures each 16-bit product into a DEPTH-entry FIFO with valid/ready handshakes on both sides. Each entry is tagged with an IEEE-754 binary16 class code, and the block keeps sticky exception flags and a saturating NaN counter. It decouples the multiplier's combinational output from the consuming pipeline (accumulator or writeback) and gives software-visible status.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- CNT_W, 8, width of the saturating NaN counter
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  product_in holds a valid multiplier result
- in_ready  output  1  buffer can accept; equals (count != DEPTH)
- product_in  input  HALF_FLOAT_W (16)  product from the multiplier
- out_valid  output  1  head entry is valid; equals (count != 0)
- out_ready  input  1  consumer accepts the head entry
- out_data  output  16  head entry product
- out_class  output  3  head entry class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 NaN
- count  output  $clog2(DEPTH)+1  current occupancy
- clear_flags  input  1  synchronous clear of the sticky flags and nan_count
- flag_nan, flag_inf, flag_zero, flag_sub  output  1 each  sticky: an accepted push had that class
- nan_count  output  CNT_W  accepted NaN pushes, saturating at all-ones

## Operation
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- Classification uses exp = product_in[14:10] and mant = product_in[9:0]:
  - exp==31, mant!=0: NaN. This covers the multiplier's 0xFFFF quiet-NaN encoding.
  - exp==31, mant==0: inf.
  - exp==0, mant==0: zero. Both +0 and -0.
  - exp==0, mant!=0: subnormal.
  - Otherwise: normal.
- The 3-bit class is computed at push time and stored alongside the 16-bit product.
- Storage: DEPTH x 19-bit register array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- count update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full (count==DEPTH):
  - in_ready is 0, so no push occurs even if a pop happens in the same cycle.
  - The upstream stalls; no data is ever dropped.
- Empty (count==0):
  - out_valid is 0.
  - out_data and out_class show the head-pointer slot contents and must be ignored by the consumer.
- Sticky flags: set on a push of the matching class. Normal results set no flag.
- nan_count: increments on a push of class NaN and holds at 2^CNT_W-1.
- clear_flags on the same cycle as a push:
  - Clear applies first, then the new push's class is recorded.
  - A NaN push with clear_flags leaves flag_nan=1 and nan_count=1.
- clear_flags does not affect FIFO contents, pointers or count.
- Reset, including reset asserted mid-burst:
  - Pointers, count, all flags and nan_count go to 0 on the next edge.
  - Storage is zeroed, so out_data=0 and out_class=0 after reset.
  - Any push or pop in the reset cycle is ignored.

## Timing
- Latency: a product pushed on edge N is visible on out_data with out_valid=1 after edge N, i.e. in cycle N+1.
- Combinational paths:
  - in_ready, out_valid and count derive only from registered count.
  - out_data and out_class are combinational reads of registered storage at the read pointer.
  - No combinational path from in_valid or product_in to any output.
  - No combinational path from out_ready to in_ready.
- Sticky flags and nan_count update on the push edge and are visible in the next cycle.
- Throughput:
  - One push and one pop per cycle are sustained while 0 < count < DEPTH.
  - At full, one cycle of pop is required before the next push can be accepted.
- The handshake is AXI-style. Once out_valid rises, out_data stays stable until popped. in_ready never depends on in_valid.

## Test plan
- Reset then single push of 0x3C00 (1.0):
  - Cycle after push: out_valid=1, out_data=0x3C00, out_class=2, count=1, no flags set.
  - Pop with out_ready=1: count returns to 0.
- Fill to full, then continuous pop and push (DEPTH=4):
  - Push 0x0000, 0x0001, 0x7C00 and 0xFFFF with out_ready=0.
  - Result: count=4, in_ready=0, a fifth in_valid is stalled.
  - Then pop all four: classes appear in order 0, 1, 3, 4.
  - Flags: flag_zero, flag_sub, flag_inf and flag_nan are all 1; nan_count=1.
- Simultaneous push and pop:
  - At count=2, hold push and pop active for 10 cycles with incrementing data 0x3C00+i.
  - count stays 2. Output order matches input order across pointer wrap-around.
- clear_flags:
  - With flag_nan=1 and nan_count=5, assert clear_flags alone: all flags 0, nan_count=0.
  - Then assert clear_flags together with a push of 0x7E00: flag_nan=1, nan_count=1.
- NaN counter saturation (CNT_W=8): 300 NaN pushes, drained as they arrive, give nan_count=255.
- Reset mid-operation:
  - At count=3 with push and pop both active, assert rst for one cycle.
  - Next cycle: count=0, out_valid=0, in_ready=1, out_data=0, all flags 0.

Source files
------------

// File: rtl/half_mult_result_buffer.sv
// Result FIFO behind the half-precision multiplier: buffers products with their binary16
// class tag and keeps sticky exception flags plus a saturating NaN counter.
module half_mult_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              product_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [2:0]               out_class,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clear_flags,
    output logic                     flag_nan,
    output logic                     flag_inf,
    output logic                     flag_zero,
    output logic                     flag_sub,
    output logic [CNT_W-1:0]         nan_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } class_e;

    logic [18:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    class_e           in_class;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] nan_base;

    always_comb begin
        in_class = CLS_NORM;
        if (product_in[14:10] == 5'h1f)
            in_class = (product_in[9:0] != 10'd0) ? CLS_NAN : CLS_INF;
        else if (product_in[14:10] == 5'h00)
            in_class = (product_in[9:0] != 10'd0) ? CLS_SUB : CLS_ZERO;
    end

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr][15:0];
    assign out_class = mem[rd_ptr][18:16];

    // Storage is cleared on reset so the empty-FIFO head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_class, product_in};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Clear takes effect first so a push in the same cycle is still recorded.
    assign nan_base = clear_flags ? '0 : nan_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_nan  <= 1'b0;
            flag_inf  <= 1'b0;
            flag_zero <= 1'b0;
            flag_sub  <= 1'b0;
            nan_count <= '0;
        end else begin
            flag_nan  <= (flag_nan  & ~clear_flags) | (push & (in_class == CLS_NAN));
            flag_inf  <= (flag_inf  & ~clear_flags) | (push & (in_class == CLS_INF));
            flag_zero <= (flag_zero & ~clear_flags) | (push & (in_class == CLS_ZERO));
            flag_sub  <= (flag_sub  & ~clear_flags) | (push & (in_class == CLS_SUB));
            if (push && (in_class == CLS_NAN) && (nan_base != '1))
                nan_count <= nan_base + CNT_W'(1);
            else
                nan_count <= nan_base;
        end
    end

endmodule
